mvm_uart_ctrl: RTL and testbench

Frame sequencer between the UART byte interfaces and the MVM datapath inside tt_um_uart_mvm.
- Assembles N_WORDS_KX received bytes into the K/X operand bus and pulses the MVM start.
- Captures the Y result, then streams N_WORDS_Y bytes to the UART transmitter under valid/ready.
- Handles inter-byte timeout and drops bytes that arrive while a frame is in flight.

---
 rtl/mvm_uart_pkg.sv | 23 ++
 rtl/mvm_uart_ctrl.sv | 157 +++++++++++++++
 tb/tb_mvm_uart_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mvm_uart_pkg.sv
// Shared types and derived sizes for the UART <-> MVM frame sequencer.
// Used by mvm_uart_ctrl, tt_um_uart_mvm and the benches.
package mvm_uart_pkg;

  typedef enum logic [1:0] {COLLECT, START, WAIT, SEND} state_e;

  localparam int MVM_R             = 2;
  localparam int MVM_C             = 2;
  localparam int MVM_W_X           = 4;
  localparam int MVM_W_K           = 4;
  localparam int MVM_W_Y_OUT       = 8;
  localparam int MVM_BITS_PER_WORD = 8;
  localparam int MVM_W_BUS_KX      = MVM_R*MVM_C*MVM_W_K + MVM_C*MVM_W_X;
  localparam int MVM_W_BUS_Y       = MVM_R*MVM_W_Y_OUT;
  localparam int MVM_N_WORDS_KX    = MVM_W_BUS_KX / MVM_BITS_PER_WORD;
  localparam int MVM_N_WORDS_Y     = MVM_W_BUS_Y / MVM_BITS_PER_WORD;

  // Counter width for a counter that runs 0..n-1; never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mvm_uart_ctrl.sv
// Frame sequencer: assembles UART bytes into the MVM operand bus, fires the
// MVM, captures its result and streams it back out under valid/ready.
module mvm_uart_ctrl
  import mvm_uart_pkg::*;
#(
  parameter int R              = MVM_R,
  parameter int C              = MVM_C,
  parameter int W_X            = MVM_W_X,
  parameter int W_K            = MVM_W_K,
  parameter int W_Y_OUT        = MVM_W_Y_OUT,
  parameter int BITS_PER_WORD  = MVM_BITS_PER_WORD,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [BITS_PER_WORD-1:0]        rx_data,
  input  logic                            rx_valid,
  output logic [R*C*W_K+C*W_X-1:0]        mvm_kx,
  output logic                            mvm_start,
  input  logic [R*W_Y_OUT-1:0]            mvm_y,
  input  logic                            mvm_y_valid,
  output logic [BITS_PER_WORD-1:0]        tx_data,
  output logic                            tx_valid,
  input  logic                            tx_ready,
  output logic                            busy,
  output logic                            overrun,
  output logic                            timeout
);

  localparam int W_BUS_KX   = R*C*W_K + C*W_X;
  localparam int W_BUS_Y    = R*W_Y_OUT;
  localparam int N_WORDS_KX = W_BUS_KX / BITS_PER_WORD;
  localparam int N_WORDS_Y  = W_BUS_Y / BITS_PER_WORD;
  localparam int CNT_W      = cnt_width(N_WORDS_KX);
  localparam int WCNT_W     = cnt_width(N_WORDS_Y);
  localparam int IDLE_W     = cnt_width(TIMEOUT_CYCLES);

  if ((W_BUS_KX % BITS_PER_WORD) != 0 || (W_BUS_Y % BITS_PER_WORD) != 0) begin : g_bad_width
    $error("mvm_uart_ctrl: KX and Y bus widths must be whole multiples of BITS_PER_WORD");
  end

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDLE_W-1:0]         idle_q, idle_d;
  logic [WCNT_W-1:0]         wcnt_q, wcnt_d;
  logic [W_BUS_KX-1:0]       shadow_q, shadow_d;
  logic [W_BUS_KX-1:0]       kx_q, kx_d;
  logic [W_BUS_Y-1:0]        y_q, y_d;
  logic [BITS_PER_WORD-1:0]  tx_data_q, tx_data_d;
  logic                      tx_valid_q, tx_valid_d;
  logic                      overrun_q, overrun_d;
  logic                      timeout_q, timeout_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idle_d     = idle_q;
    wcnt_d     = wcnt_q;
    shadow_d   = shadow_q;
    kx_d       = kx_q;
    y_d        = y_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    overrun_d  = 1'b0;
    timeout_d  = 1'b0;

    // Bytes arriving while a frame is in flight are dropped, never queued.
    if (state_q != COLLECT && rx_valid) overrun_d = 1'b1;

    case (state_q)
      COLLECT: begin
        if (rx_valid) begin
          shadow_d[int'(cnt_q)*BITS_PER_WORD +: BITS_PER_WORD] = rx_data;
          idle_d = '0;
          if (cnt_q == CNT_W'(N_WORDS_KX-1)) begin
            kx_d    = shadow_d;
            cnt_d   = '0;
            state_d = START;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (TIMEOUT_CYCLES > 0 && cnt_q != '0) begin
          if (idle_q == IDLE_W'(TIMEOUT_CYCLES-1)) begin
            cnt_d     = '0;
            idle_d    = '0;
            shadow_d  = '0;
            timeout_d = 1'b1;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      START, WAIT: begin
        // A result landing in the START cycle is taken as well.
        if (mvm_y_valid) begin
          y_d        = mvm_y;
          wcnt_d     = '0;
          tx_valid_d = 1'b1;
          tx_data_d  = mvm_y[BITS_PER_WORD-1:0];
          state_d    = SEND;
        end else begin
          state_d = WAIT;
        end
      end
      SEND: begin
        if (tx_valid_q && tx_ready) begin
          if (wcnt_q == WCNT_W'(N_WORDS_Y-1)) begin
            tx_valid_d = 1'b0;
            wcnt_d     = '0;
            state_d    = COLLECT;
          end else begin
            wcnt_d    = wcnt_q + 1'b1;
            tx_data_d = y_q[(int'(wcnt_q)+1)*BITS_PER_WORD +: BITS_PER_WORD];
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= COLLECT;
      cnt_q      <= '0;
      idle_q     <= '0;
      wcnt_q     <= '0;
      shadow_q   <= '0;
      kx_q       <= '0;
      y_q        <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idle_q     <= idle_d;
      wcnt_q     <= wcnt_d;
      shadow_q   <= shadow_d;
      kx_q       <= kx_d;
      y_q        <= y_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

  assign mvm_kx    = kx_q;
  assign mvm_start = (state_q == START);
  assign busy      = (state_q != COLLECT);
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign overrun   = overrun_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_mvm_uart_ctrl.sv
// Bench for mvm_uart_ctrl: scoreboarded operand/result bytes against a signed
// 2x2 MVM reference, plus backpressure, timeout, overrun and reset scenarios.
module tb_mvm_uart_ctrl;
  import mvm_uart_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [23:0] mvm_kx;
  logic        mvm_start;
  logic [15:0] mvm_y;
  logic        mvm_y_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        overrun;
  logic        timeout;

  mvm_uart_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .mvm_kx(mvm_kx), .mvm_start(mvm_start),
    .mvm_y(mvm_y), .mvm_y_valid(mvm_y_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .overrun(overrun), .timeout(timeout)
  );

  // Clock / reset / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q[$];
  logic [23:0] kx_exp_q[$];
  int          n_start = 0, n_hs = 0, n_ovr = 0, n_to = 0, n_frames = 0;
  int          lat_fixed = -1;
  int          rdy_mode  = 0;
  logic [23:0] last_kx = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Signed 2x2 MVM, k(r,c) at nibble r*C+c above the x vector, rows truncated to 8 bits.
  function automatic logic [15:0] ref_mvm(input logic [23:0] kx);
    logic [15:0] y;
    logic [3:0]  kn, xn;
    int          acc;
    y = '0;
    for (int r = 0; r < 2; r++) begin
      acc = 0;
      for (int c = 0; c < 2; c++) begin
        kn = kx[8 + (r*2+c)*4 +: 4];
        xn = kx[c*4 +: 4];
        acc += int'($signed(kn)) * int'($signed(xn));
      end
      y[r*8 +: 8] = 8'(acc);
    end
    return y;
  endfunction

  // Driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic push_expect(input logic [23:0] kx);
    logic [15:0] y;
    y = ref_mvm(kx);
    kx_exp_q.push_back(kx);
    exp_q.push_back(y[7:0]);
    exp_q.push_back(y[15:8]);
    last_kx = kx;
    n_frames++;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!busy && n < 10) begin @(negedge clk); n++; end
    chk("busy_rise", busy, 1'b1);
    n = 0;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    chk("busy_fall", busy, 1'b0);
  endtask

  task automatic send_frame(input logic [23:0] kx, input int max_gap, input bit do_wait);
    push_expect(kx);
    for (int i = 0; i < 3; i++) begin
      send_byte(kx[i*8 +: 8]);
      if (i < 2) repeat ($urandom_range(0, max_gap)) @(posedge clk);
    end
    if (do_wait) wait_done();
  endtask

  task automatic wait_tx_valid();
    int n;
    n = 0;
    while (!tx_valid && n < 200) begin @(negedge clk); n++; end
    chk("tx_valid_rise", tx_valid, 1'b1);
  endtask

  // Transmitter ready driver; mode 3 leaves tx_ready to the test body.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: tx_ready = 1'b1;
        1: tx_ready = 1'($urandom_range(0, 1));
        2: tx_ready = 1'b0;
        default: ;
      endcase
    end
  end

  // MVM environment model: answers each start after a fixed or random latency.
  initial begin
    logic [15:0] yv;
    int          lat;
    mvm_y_valid = 1'b0;
    mvm_y       = '0;
    forever begin
      @(negedge clk);
      if (!rst && mvm_start) begin
        yv  = ref_mvm(mvm_kx);
        lat = (lat_fixed >= 0) ? lat_fixed : $urandom_range(0, 50);
        if (lat > 0) begin
          repeat (lat) @(posedge clk);
          #1;
        end
        mvm_y       = yv;
        mvm_y_valid = 1'b1;
        @(posedge clk); #1;
        mvm_y_valid = 1'b0;
        mvm_y       = 16'($urandom);
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an output.
  initial begin
    logic       prev_stall, prev_start;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_start = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        prev_start = 1'b0;
      end else begin
        if (mvm_start) begin
          n_start++;
          chk("start_single_cycle", prev_start, 1'b0);
          chk("kx_expected", kx_exp_q.size() > 0, 1'b1);
          if (kx_exp_q.size() > 0) chk("mvm_kx", mvm_kx, kx_exp_q.pop_front());
        end
        if (prev_stall) begin
          chk("tx_hold_valid", tx_valid, 1'b1);
          chk("tx_hold_data", tx_data, prev_data);
        end
        if (tx_valid && tx_ready) begin
          n_hs++;
          chk("tx_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) chk("tx_data", tx_data, exp_q.pop_front());
        end
        if (overrun) n_ovr++;
        if (timeout) n_to++;
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_start = mvm_start;
      end
    end
  end

  // Main sequence
  initial begin
    int hs0, to0, ovr0, st0;
    rst      = 1'b1;
    rx_data  = '0;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mvm_kx", mvm_kx, 24'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h0);
    chk("rst_start", mvm_start, 1'b0);
    chk("rst_pulses", {overrun, timeout}, 2'b00);
    rst = 1'b0;

    // Frame assembly and start latency
    lat_fixed = 3;
    rdy_mode  = 0;
    push_expect(24'h654321);
    send_byte(8'h21);
    repeat ($urandom_range(0, 11)) @(posedge clk);
    send_byte(8'h43);
    repeat ($urandom_range(0, 11)) @(posedge clk);
    send_byte(8'h65);
    chk("start_latency", mvm_start, 1'b1);
    wait_done();
    chk("kx_stable", mvm_kx, 24'h654321);

    // Backpressure on byte 0
    @(negedge clk);
    rdy_mode = 2;
    hs0 = n_hs;
    send_frame(24'h654321, 5, 1'b0);
    wait_tx_valid();
    repeat (7) begin
      @(negedge clk);
      chk("bp_valid", tx_valid, 1'b1);
      chk("bp_data", tx_data, 8'h0B);
    end
    rdy_mode = 0;
    wait_done();
    chk("bp_handshakes", n_hs - hs0, 2);

    // Timeout discards a partial frame
    to0 = n_to;
    st0 = n_start;
    send_byte(8'hAA);
    repeat (20) @(negedge clk);
    chk("timeout_count", n_to - to0, 1);
    chk("timeout_kx_kept", mvm_kx, last_kx);
    chk("timeout_no_start", n_start - st0, 0);
    chk("timeout_busy", busy, 1'b0);

    // A byte on the cycle the timeout would fire wins
    to0 = n_to;
    push_expect(24'h6543AA);
    send_byte(8'hAA);
    repeat (14) @(posedge clk);
    send_byte(8'h43);
    send_byte(8'h65);
    wait_done();
    chk("boundary_no_timeout", n_to - to0, 0);
    send_frame(24'h654321, 8, 1'b1);

    // Overrun during WAIT
    lat_fixed = 30;
    ovr0 = n_ovr;
    send_frame(24'h1F_E3_72, 4, 1'b0);
    repeat (2) @(posedge clk);
    send_byte(8'h55);
    wait_done();
    chk("overrun_count", n_ovr - ovr0, 1);
    lat_fixed = 2;
    send_frame(24'h9C_47_B5, 6, 1'b1);

    // Asynchronous reset in SEND after byte 0
    @(negedge clk);
    rdy_mode = 3;
    tx_ready = 1'b0;
    send_frame(24'h7A_21_3F, 3, 1'b0);
    wait_tx_valid();
    @(posedge clk); #1;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    @(negedge clk);
    chk("rst_pending_bytes", exp_q.size(), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_tx_valid", tx_valid, 1'b0);
    chk("arst_tx_data", tx_data, 8'h0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_mvm_kx", mvm_kx, 24'h0);
    exp_q.delete();
    last_kx = '0;
    @(negedge clk);
    rst = 1'b0;
    rdy_mode = 0;
    send_frame(24'h654321, 4, 1'b1);

    // Random frames, random latency, random ready
    lat_fixed = -1;
    rdy_mode  = 1;
    for (int f = 0; f < 10; f++) begin
      send_frame(24'($urandom), 10, 1'b1);
    end

    repeat (5) @(negedge clk);
    chk("final_tx_queue_empty", exp_q.size(), 0);
    chk("final_kx_queue_empty", kx_exp_q.size(), 0);
    chk("final_start_count", n_start, n_frames);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
